// File: rtl/ucode_pkg.sv
// Shared micro-instruction types, field helpers and fetch-stage constants.
package ucode_pkg;

    localparam int unsigned ROM_DEPTH = 4096;
    localparam int unsigned UCODE_AW  = $clog2(ROM_DEPTH);
    localparam int unsigned UCODE_DW  = 112;

    typedef logic [UCODE_AW-1:0] uaddr_t;
    typedef logic [UCODE_DW:1]   uinstr_t;

    localparam logic [3:0] SQI_CONT = 4'd14;
    localparam logic [1:0] MAP_PE   = 2'd0;

    // Next-pc source, listed lowest to highest priority
    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_REDIR,
        SEL_CALL,
        SEL_RET,
        SEL_TRAP
    } pc_sel_e;

    function automatic logic [3:0] uf_sqi(input uinstr_t w);
        return w[112:109];
    endfunction

    function automatic uaddr_t uf_a(input uinstr_t w);
        return w[108:97];
    endfunction

    function automatic logic [1:0] uf_map(input uinstr_t w);
        return w[96:95];
    endfunction

endpackage

// File: rtl/ucode_retstack.sv
// Micro-return stack: LIFO of micro-addresses with full/empty flags.
module ucode_retstack #(
    parameter int unsigned AW          = 12,
    parameter int unsigned STACK_DEPTH = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_data,
    output logic [AW-1:0] top,
    output logic          full,
    output logic          empty
);

    localparam int unsigned CW = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [AW-1:0] mem [STACK_DEPTH];
    logic [CW-1:0] cnt;
    logic [CW-1:0] top_ptr;

    assign top_ptr = cnt - CW'(1);
    assign top     = mem[top_ptr[IW-1:0]];
    assign full    = (cnt == CW'(STACK_DEPTH));
    assign empty   = (cnt == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (pop && !empty) begin
            cnt <= cnt - CW'(1);
        end else if (push && !full) begin
            mem[cnt[IW-1:0]] <= push_data;
            cnt              <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/ucode_fetch.sv
// Microcode fetch stage: micro-PC sequencing, ROM addressing and execute register.
// Optional retired-instruction counter enabled by defining UCODE_FETCH_RETIRE_EN.
module ucode_fetch
    import ucode_pkg::*;
#(
    parameter int unsigned   AW          = UCODE_AW,
    parameter int unsigned   DW          = UCODE_DW,
    parameter int unsigned   STACK_DEPTH = 5,
    parameter logic [AW-1:0] TRAP_VECTOR = '1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          redirect,
    input  logic          call,
    input  logic          ret,
    input  logic          trap,
    input  logic [AW-1:0] target,
    output logic [AW-1:0] rom_addr,
    input  logic [DW:1]   rom_data,
    output logic [AW-1:0] pc_f,
    output logic [AW-1:0] pc_x,
    output logic [DW:1]   opcode_x,
    output logic          valid_x,
    output logic [AW-1:0] trap_pc,
    output logic          stk_err,
    output logic [31:0]   retire_cnt
);

    pc_sel_e       sel;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] pc_next;
    logic [AW-1:0] stk_top;
    logic          stk_full;
    logic          stk_empty;
    logic          stk_push;
    logic          stk_pop;
    logic          err_set;

    assign rom_addr = pc_f;
    assign pc_inc   = pc_f + AW'(1);

    // Controls only count when a real instruction is in execute and the stage advances
    always_comb begin
        sel = SEL_SEQ;
        if (valid_x && !stall) begin
            if (trap)          sel = SEL_TRAP;
            else if (ret)      sel = SEL_RET;
            else if (call)     sel = SEL_CALL;
            else if (redirect) sel = SEL_REDIR;
        end
    end

    always_comb begin
        pc_next  = pc_inc;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        err_set  = 1'b0;
        unique case (sel)
            SEL_TRAP:  pc_next = TRAP_VECTOR;
            SEL_RET: begin
                pc_next = stk_empty ? pc_inc : stk_top;
                stk_pop = !stk_empty;
                err_set = stk_empty;
            end
            SEL_CALL: begin
                pc_next  = target;
                stk_push = !stk_full;
                err_set  = stk_full;
            end
            SEL_REDIR: pc_next = target;
            default:   pc_next = pc_inc;
        endcase
    end

    ucode_retstack #(
        .AW         (AW),
        .STACK_DEPTH(STACK_DEPTH)
    ) u_retstack (
        .clk      (clk),
        .reset    (reset),
        .push     (stk_push),
        .pop      (stk_pop),
        .push_data(pc_x + AW'(1)),
        .top      (stk_top),
        .full     (stk_full),
        .empty    (stk_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_f     <= '0;
            pc_x     <= '0;
            opcode_x <= '0;
            valid_x  <= 1'b0;
            trap_pc  <= '0;
            stk_err  <= 1'b0;
        end else if (!stall) begin
            pc_f <= pc_next;
            pc_x <= pc_f;
            if (sel != SEL_SEQ) begin
                opcode_x <= '0;
                valid_x  <= 1'b0;
            end else begin
                opcode_x <= rom_data;
                valid_x  <= 1'b1;
            end
            if (sel == SEL_TRAP) trap_pc <= pc_x;
            if (err_set)         stk_err <= 1'b1;
        end
    end

`ifdef UCODE_FETCH_RETIRE_EN
    logic [31:0] retire_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retire_q <= '0;
        end else if (valid_x && !stall) begin
            retire_q <= retire_q + 32'd1;
        end
    end

    assign retire_cnt = retire_q;
`else
    assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_ucode_fetch.sv
// Directed bench for ucode_fetch with a queue-based reference model checked every cycle.
module tb_ucode_fetch;

    localparam int AW    = 12;
    localparam int DW    = 112;
    localparam int DEPTH = 5;
    localparam int TRAPV = 4095;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          stall = 1'b0;
    logic          redirect = 1'b0;
    logic          call = 1'b0;
    logic          ret = 1'b0;
    logic          trap = 1'b0;
    logic [AW-1:0] target = '0;
    logic [AW-1:0] rom_addr;
    logic [DW:1]   rom_data;
    logic [AW-1:0] pc_f;
    logic [AW-1:0] pc_x;
    logic [DW:1]   opcode_x;
    logic          valid_x;
    logic [AW-1:0] trap_pc;
    logic          stk_err;
    logic [31:0]   retire_cnt;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    function automatic logic [DW:1] rom_word(input logic [AW-1:0] a);
        return {{(DW-AW){1'b0}}, a};
    endfunction

    assign rom_data = rom_word(rom_addr);

    ucode_fetch #(
        .AW         (AW),
        .DW         (DW),
        .STACK_DEPTH(DEPTH),
        .TRAP_VECTOR(12'hFFF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .redirect  (redirect),
        .call      (call),
        .ret       (ret),
        .trap      (trap),
        .target    (target),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .pc_f      (pc_f),
        .pc_x      (pc_x),
        .opcode_x  (opcode_x),
        .valid_x   (valid_x),
        .trap_pc   (trap_pc),
        .stk_err   (stk_err),
        .retire_cnt(retire_cnt)
    );

    // Reference model: plain integers and a queue for the return stack
    int          m_pc_f, m_pc_x, m_trap_pc, m_valid, m_err;
    logic [DW:1] m_op;
    longint      m_ret;
    int          m_stk[$];

    always @(posedge clk or negedge reset) begin
        int npc;
        int ctl;
        if (!reset) begin
            m_pc_f = 0; m_pc_x = 0; m_op = '0; m_valid = 0;
            m_trap_pc = 0; m_err = 0; m_ret = 0;
            m_stk.delete();
        end else if (!stall) begin
            if (m_valid != 0) m_ret = (m_ret + 1) % 64'h1_0000_0000;
            ctl = (m_valid != 0) && (trap || ret || call || redirect);
            npc = (m_pc_f + 1) % 4096;
            if (m_valid != 0 && trap) begin
                npc = TRAPV;
                m_trap_pc = m_pc_x;
            end else if (m_valid != 0 && ret) begin
                if (m_stk.size() == 0) m_err = 1;
                else npc = m_stk.pop_back();
            end else if (m_valid != 0 && call) begin
                if (m_stk.size() == DEPTH) m_err = 1;
                else m_stk.push_back((m_pc_x + 1) % 4096);
                npc = int'(target);
            end else if (m_valid != 0 && redirect) begin
                npc = int'(target);
            end
            m_op    = (ctl != 0) ? '0 : rom_word(AW'(m_pc_f));
            m_valid = (ctl != 0) ? 0 : 1;
            m_pc_x  = m_pc_f;
            m_pc_f  = npc;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        chk("pc_f", pc_f, m_pc_f);
        chk("rom_addr", rom_addr, m_pc_f);
        chk("pc_x", pc_x, m_pc_x);
        chk("opcode_x", opcode_x, m_op);
        chk("valid_x", valid_x, m_valid);
        chk("trap_pc", trap_pc, m_trap_pc);
        chk("stk_err", stk_err, m_err);
`ifdef UCODE_FETCH_RETIRE_EN
        chk("retire_cnt", retire_cnt, m_ret);
`else
        chk("retire_cnt", retire_cnt, 0);
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pcx(input int v);
        int n = 0;
        while (!(m_pc_x == v && m_valid != 0) && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) begin
            checks++;
            $display("FAIL wait_pcx: pc_x %0d never reached %0d", m_pc_x, v);
        end
    endtask

    task automatic jump(input int t);
        redirect = 1'b1; target = AW'(t);
        step();
        redirect = 1'b0;
        step();
    endtask

    task automatic do_ret();
        ret = 1'b1;
        step();
        ret = 1'b0;
    endtask

    initial begin
        int exp_ret[5] = '{231, 221, 211, 201, 22};
        longint r0;

        // 1: reset and straight-line fetch
        repeat (2) step();
        chk("rst_pc_x", pc_x, 0);
        chk("rst_valid", valid_x, 0);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("seq_pc_x", pc_x, i);
            chk("seq_valid", valid_x, 1);
            chk("seq_op", opcode_x, i);
        end

        // 2: redirect held into the bubble; the bubble cycle must ignore it
        wait_pcx(10);
        redirect = 1'b1; target = 12'd44;
        step();
        chk("redir_bub_pc_x", pc_x, 11);
        chk("redir_bub_valid", valid_x, 0);
        step();
        redirect = 1'b0;
        chk("redir_pc_x", pc_x, 44);
        chk("redir_valid", valid_x, 1);
        chk("redir_pc_f", pc_f, 45);

        // 3: call / ret round trip
        jump(18);
        wait_pcx(20);
        call = 1'b1; target = 12'd100;
        step();
        call = 1'b0;
        chk("call_bub", valid_x, 0);
        step(); chk("call_t0", pc_x, 100);
        step(); chk("call_t1", pc_x, 101);
        step(); chk("call_t2", pc_x, 102);
        do_ret();
        chk("ret_bub", valid_x, 0);
        step();
        chk("ret_pc_x", pc_x, 21);
        chk("ret_valid", valid_x, 1);
        chk("ret_err", stk_err, 0);

        // 4: overflow on the sixth call, then unwind past empty
        for (int k = 0; k < 6; k++) begin
            if (k == 5) chk("pre_ovf_err", stk_err, 0);
            call = 1'b1; target = AW'(200 + 10 * k);
            step();
            call = 1'b0;
            step();
        end
        chk("ovf_err", stk_err, 1);
        chk("ovf_pc_x", pc_x, 250);
        for (int k = 0; k < 5; k++) begin
            do_ret();
            step();
            chk("unwind_pc_x", pc_x, exp_ret[k]);
        end
        do_ret();
        chk("udf_bub_pc_x", pc_x, 23);
        chk("udf_bub_valid", valid_x, 0);
        step();
        chk("udf_pc_x", pc_x, 24);

        // 5: trap with simultaneous call leaves the stack alone
        jump(290);
        call = 1'b1; target = 12'd298;
        step();
        call = 1'b0;
        wait_pcx(300);
        trap = 1'b1; call = 1'b1; target = 12'd5;
        step();
        trap = 1'b0; call = 1'b0;
        chk("trap_pc", trap_pc, 300);
        chk("trap_pc_f", pc_f, 12'hFFF);
        step(); chk("trap_vec", pc_x, 12'hFFF);
        step(); chk("trap_wrap", pc_x, 0);
        do_ret();
        step();
        chk("trap_stack", pc_x, 291);

        // 6: stall holds everything, then async reset mid-stall
        jump(48);
        wait_pcx(50);
        stall = 1'b1;
        r0 = m_ret;
        repeat (3) begin
            step();
            chk("stall_pc_x", pc_x, 50);
            chk("stall_pc_f", pc_f, 51);
        end
`ifdef UCODE_FETCH_RETIRE_EN
        chk("stall_retire", retire_cnt, r0);
`else
        chk("stall_retire", retire_cnt, 0);
`endif
        #2 reset = 1'b0;
        #1;
        chk("arst_pc_f", pc_f, 0);
        chk("arst_pc_x", pc_x, 0);
        chk("arst_valid", valid_x, 0);
        chk("arst_err", stk_err, 0);
        chk("arst_trap_pc", trap_pc, 0);
        chk("arst_retire", retire_cnt, 0);
        step();
        stall = 1'b0;
        step();
        reset = 1'b1;
        repeat (3) step();
        chk("post_rst_pc_x", pc_x, 2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
